// File: rtl/addsub_result_fifo.sv
// Four-entry result FIFO behind a 4-bit add/sub stage: stores {m, V, carry, C} per result.
// Optional overflow-event counter (ovf_cnt port) is built only when ADDSUB_OVF_COUNT_EN is defined.
module addsub_result_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_C,
  input  logic       in_carry,
  input  logic       in_V,
  input  logic       in_m,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_C,
  output logic       out_carry,
  output logic       out_V,
  output logic       out_m,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] count
`ifdef ADDSUB_OVF_COUNT_EN
  ,
  output logic [3:0] ovf_cnt
`endif
);

  typedef logic [6:0] entry_t;

  entry_t     mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       push;
  logic       pop;

  // Flow control looks only at the registered count, so a full FIFO refuses
  // a write even when the head is popped in the same cycle.
  always_comb begin
    in_ready  = (count != 3'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    {out_m, out_V, out_carry, out_C} = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_m, in_V, in_carry, in_C};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ADDSUB_OVF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (push && in_V && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Self-checking bench for addsub_result_fifo against a queue-based reference model.
// Overflow-counter checks are compiled in only when ADDSUB_OVF_COUNT_EN is defined.
module tb_addsub_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_C = '0;
  logic       in_carry = 1'b0;
  logic       in_V = 1'b0;
  logic       in_m = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_C;
  logic       out_carry;
  logic       out_V;
  logic       out_m;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
`ifdef ADDSUB_OVF_COUNT_EN
  logic [3:0] ovf_cnt;
`endif

  addsub_result_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_C      (in_C),
    .in_carry  (in_carry),
    .in_V      (in_V),
    .in_m      (in_m),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_C     (out_C),
    .out_carry (out_carry),
    .out_V     (out_V),
    .out_m     (out_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef ADDSUB_OVF_COUNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  logic [6:0] mq[$];
  int         m_ovf = 0;

  // Reference add/sub result entry {m, V, carry, C} from plain integer arithmetic.
  function automatic logic [6:0] make_entry(input int a, input int b, input bit m);
    int         s;
    int         sa;
    int         sb;
    int         r;
    logic [4:0] s5;
    logic       v;
    s  = m ? (a + ((~b) & 15) + 1) : (a + b);
    s5 = 5'(s);
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    r  = m ? sa - sb : sa + sb;
    v  = (r < -8) || (r > 7);
    return {m, v, s5[4], s5[3:0]};
  endfunction

  function automatic logic [6:0] rand_entry();
    return make_entry(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
  endfunction

  // Drive one cycle, advance the model across the edge, leave time at edge+1.
  task automatic step(input bit v, input logic [6:0] d, input bit r);
    bit acc;
    bit pp;
    in_valid  = v;
    {in_m, in_V, in_carry, in_C} = d;
    out_ready = r;
    @(posedge clk);
    acc = v && (mq.size() < 4);
    pp  = r && (mq.size() > 0);
    if (pp) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(d);
      if (d[5] && m_ovf < 15) m_ovf++;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    {in_m, in_V, in_carry, in_C} = 7'h2b;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
`ifdef ADDSUB_OVF_COUNT_EN
    total++; if (ovf_cnt !== 4'd0) $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt); else pass_cnt++;
`endif
    apply_reset();
  endtask

  task automatic test_single_write();
    apply_reset();
    step(1'b1, make_entry(4, 7, 1'b0), 1'b0);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got=%b exp=1", out_valid); else pass_cnt++;
    total++; if (out_C !== 4'd11) $display("FAIL single_out_C got=%0d exp=11", out_C); else pass_cnt++;
    total++; if (out_V !== 1'b1) $display("FAIL single_out_V got=%b exp=1", out_V); else pass_cnt++;
    total++; if (count !== 3'd1) $display("FAIL single_count got=%0d exp=1", count); else pass_cnt++;
`ifdef ADDSUB_OVF_COUNT_EN
    total++; if (ovf_cnt !== 4'd1) $display("FAIL single_ovf got=%0d exp=1", ovf_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_fill_drain();
    logic [3:0] exp_c[4]  = '{4'd11, 4'd9, 4'd8, 4'd3};
    logic       exp_cy[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_m[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    step(1'b1, make_entry(4, 7, 1'b0), 1'b0);
    step(1'b1, make_entry(13, 12, 1'b0), 1'b0);
    step(1'b1, make_entry(13, 5, 1'b1), 1'b0);
    step(1'b1, make_entry(5, 2, 1'b1), 1'b0);
    total++; if (count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_C, out_carry, out_m} !== {exp_c[i], exp_cy[i], exp_m[i]})
        $display("FAIL drain_%0d got C=%0d carry=%b m=%b exp C=%0d carry=%b m=%b",
                 i, out_C, out_carry, out_m, exp_c[i], exp_cy[i], exp_m[i]);
      else pass_cnt++;
      step(1'b0, '0, 1'b1);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_full_drop();
    logic [6:0] dropped;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, rand_entry(), 1'b0);
    dropped = rand_entry();
    step(1'b1, dropped, 1'b1);
    total++; if (count !== 3'd3) $display("FAIL full_drop_count got=%0d exp=3", count); else pass_cnt++;
    while (mq.size() > 0) begin
      total++;
      if ({out_m, out_V, out_carry, out_C} !== mq[0])
        $display("FAIL full_drop_order got=%h exp=%h", {out_m, out_V, out_carry, out_C}, mq[0]);
      else pass_cnt++;
      step(1'b0, '0, 1'b1);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL full_drop_extra got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    step(1'b1, rand_entry(), 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_m, out_V, out_carry, out_C} !== mq[0])
        $display("FAIL b2b_head_%0d got=%h exp=%h", i, {out_m, out_V, out_carry, out_C}, mq[0]);
      else pass_cnt++;
      step(1'b1, rand_entry(), 1'b1);
      total++; if (count !== 3'd1) $display("FAIL b2b_count_%0d got=%0d exp=1", i, count); else pass_cnt++;
    end
    total++;
    if ({out_m, out_V, out_carry, out_C} !== mq[0])
      $display("FAIL b2b_last got=%h exp=%h", {out_m, out_V, out_carry, out_C}, mq[0]);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rand_entry(), 1'b0);
    in_valid = 1'b0;
    total++; if (count !== 3'd3) $display("FAIL arst_pre_count got=%0d exp=3", count); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0) $display("FAIL arst_count got=%0d exp=0", count); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 99) < 60), rand_entry(), bit'($urandom_range(0, 99) < 50));
      total++;
      if (count !== 3'(mq.size())) $display("FAIL rand_count_%0d got=%0d exp=%0d", i, count, mq.size());
      else pass_cnt++;
      total++;
      if ({in_ready, out_valid} !== {mq.size() < 4, mq.size() > 0})
        $display("FAIL rand_flags_%0d got=%b%b exp=%b%b", i, in_ready, out_valid, mq.size() < 4, mq.size() > 0);
      else pass_cnt++;
      if (mq.size() > 0) begin
        total++;
        if ({out_m, out_V, out_carry, out_C} !== mq[0])
          $display("FAIL rand_head_%0d got=%h exp=%h", i, {out_m, out_V, out_carry, out_C}, mq[0]);
        else pass_cnt++;
      end
`ifdef ADDSUB_OVF_COUNT_EN
      total++;
      if (ovf_cnt !== 4'(m_ovf)) $display("FAIL rand_ovf_%0d got=%0d exp=%0d", i, ovf_cnt, m_ovf);
      else pass_cnt++;
`endif
    end
  endtask

`ifdef ADDSUB_OVF_COUNT_EN
  task automatic test_ovf_saturate();
    apply_reset();
    for (int i = 0; i < 17; i++) step(1'b1, make_entry(7, 1, 1'b0), 1'b1);
    in_valid = 1'b0;
    total++; if (ovf_cnt !== 4'd15) $display("FAIL ovf_sat got=%0d exp=15", ovf_cnt); else pass_cnt++;
    total++; if (4'(m_ovf) !== ovf_cnt) $display("FAIL ovf_model got=%0d exp=%0d", ovf_cnt, m_ovf); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_fill_drain();
    test_full_drop();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef ADDSUB_OVF_COUNT_EN
    test_ovf_saturate();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
